t20_innings_scorer: RTL and testbench
=====================================

Name: t20_innings_scorer

Overview:
- Downstream consumer of the 4-bit LFSR pseudo-random value. It turns each bowler "delivery" press into a ball outcome using the fixed cricket decode table.
- It accumulates runs, wickets, balls and overs for one T20 innings, and flags innings completion (all out, overs exhausted, or target reached).
- Outputs feed the display/scoreboard stage.

Parameters:
- MAX_OVERS, 20, overs per innings.
- MAX_WICKETS, 10, wickets that end the innings.
- RUN_W, 10, width of run counter.
- RUN_SAT, 999, run counter saturation value.

Ports:
- clk_fpga  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  level/pulse; begins a new innings from IDLE or DONE.
- chase_en  in  1  sampled at start; enables target termination.
- target  in  RUN_W  sampled at start; runs needed when chase_en=1.
- delivery  in  1  raw delivery request; the rising edge is detected internally.
- lfsr_val  in  4  current LFSR value, sampled on the detected edge.
- runs  out  RUN_W  innings total.
- wickets  out  4  wickets fallen.
- overs  out  5  completed overs.
- balls  out  3  legal balls in current over, 0..5.
- free_hit  out  1  next delivery is a free hit.
- outcome_code  out  4  last outcome (package enum).
- outcome_valid  out  1  one-cycle pulse when counters update.
- innings_done  out  1  high in DONE.

Behaviour:
- Reset (async, reset_n=0):
  - State=IDLE; all counters, free_hit, outcome_valid and innings_done are 0.
  - outcome_code=DOT; delivery_q=1, which suppresses a spurious edge on release.
- Edge detection: del_edge = delivery & ~delivery_q. delivery_q is registered every cycle in every state.
- FSM has three states, IDLE, PLAY and DONE:
  - IDLE -> PLAY on start: clear counters, latch target/chase_en. A del_edge in the same cycle is ignored.
  - PLAY: each del_edge decodes lfsr_val. Counters, outcome_code and outcome_valid update on the next rising edge (latency 1). start is ignored.
  - PLAY -> DONE in the same cycle as the update that meets a termination condition (see below).
  - DONE: del_edge is ignored. start -> clear counters, relatch inputs, go to PLAY.
- Decode table:
  - 0-2: DOT, 0 runs, legal.
  - 3-6: SINGLE, +1, legal.
  - 7-9: DOUBLE, +2, legal.
  - 10: TRIPLE, +3, legal.
  - 11: FOUR, +4, legal.
  - 12: SIX, +6, legal.
  - 13: WIDE, +1, not legal.
  - 14: NOBALL, +1, not legal, sets free_hit.
  - 15: WICKET, 0 runs, legal, wickets+1.
- Free hit:
  - While free_hit=1, a WICKET decode is scored as DOT, with outcome_code=DOT.
  - free_hit clears on the next legal ball. It stays set through a WIDE and is re-armed by another NOBALL.
- Over counting (legal ball only):
  - balls<5: balls+1.
  - balls==5: balls<=0, overs+1.
- Run arithmetic: runs <= min(runs+delta, RUN_SAT).
- Termination, evaluated on the post-update values:
  - wickets==MAX_WICKETS, or
  - overs==MAX_OVERS, or
  - chase_en && runs>=target.
  - If several conditions hold together, the single transition to DONE applies; counters show the final values.
- chase_en=1 with target=0: the innings goes to DONE on the first counted delivery.
- outcome_valid pulses exactly once per counted delivery. It never pulses in IDLE or DONE.
- Held delivery counts once. Re-pressing on consecutive cycles (1,0,1) counts twice.
- reset_n asserted mid-innings clears immediately, without waiting for a clock edge.

Decomposition:
- Package t20_pkg holds:
  - outcome_e enum: DOT, SINGLE, DOUBLE, TRIPLE, FOUR, SIX, WIDE, NOBALL, WICKET.
  - state_e enum: IDLE, PLAY, DONE.
  - Constants BALLS_PER_OVER=6 and the run value per outcome.
- Sub-module t20_outcome_decode (combinational): lfsr_val -> {outcome_e, run_delta[2:0], legal, is_wicket}.
- Free-hit override and all counters live in the top module.

Test Plan:
- Reset/start: reset_n low then high, start pulse, lfsr_val=4, one delivery edge -> runs=1, balls=1, outcome_code=SINGLE, outcome_valid high one cycle.
- Over rollover: six deliveries with lfsr_val=12 -> runs=36, overs=1, balls=0. Then lfsr_val=13 -> runs=37, balls=0.
- Free hit: lfsr_val=14 then 15 -> runs=1, wickets=0, outcome_code=DOT, balls=1, free_hit cleared. Next 15 -> wickets=1.
- All out: ten deliveries with lfsr_val=15 -> wickets=10, innings_done=1. An 11th delivery -> no change, no outcome_valid.
- Chase: start with chase_en=1, target=10; deliveries 12 then 11 -> runs=10, DONE after the second update. start again -> counters cleared, PLAY.
- Edge/hold and async reset: delivery held high 5 cycles -> exactly one update. Assert reset_n between clock edges mid-innings -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/t20_pkg.sv
// rtl/t20_pkg.sv - shared types and constants for the T20 innings scorer
package t20_pkg;

  typedef enum logic [3:0] {
    DOT    = 4'd0,
    SINGLE = 4'd1,
    DOUBLE = 4'd2,
    TRIPLE = 4'd3,
    FOUR   = 4'd4,
    SIX    = 4'd5,
    WIDE   = 4'd6,
    NOBALL = 4'd7,
    WICKET = 4'd8
  } outcome_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int BALLS_PER_OVER = 6;

  function automatic logic [2:0] run_value(input outcome_e o);
    logic [2:0] r;
    r = 3'd0;
    case (o)
      SINGLE: r = 3'd1;
      DOUBLE: r = 3'd2;
      TRIPLE: r = 3'd3;
      FOUR:   r = 3'd4;
      SIX:    r = 3'd6;
      WIDE:   r = 3'd1;
      NOBALL: r = 3'd1;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/t20_outcome_decode.sv
// rtl/t20_outcome_decode.sv - maps a 4-bit LFSR value onto a ball outcome
module t20_outcome_decode
  import t20_pkg::*;
(
  input  logic [3:0] lfsr_val,
  output outcome_e   outcome,
  output logic [2:0] run_delta,
  output logic       legal,
  output logic       is_wicket
);

  always_comb begin
    outcome = DOT;
    if (lfsr_val <= 4'd2)      outcome = DOT;
    else if (lfsr_val <= 4'd6) outcome = SINGLE;
    else if (lfsr_val <= 4'd9) outcome = DOUBLE;
    else begin
      case (lfsr_val)
        4'd10:   outcome = TRIPLE;
        4'd11:   outcome = FOUR;
        4'd12:   outcome = SIX;
        4'd13:   outcome = WIDE;
        4'd14:   outcome = NOBALL;
        default: outcome = WICKET;
      endcase
    end
  end

  assign run_delta = run_value(outcome);
  assign legal     = (outcome != WIDE) && (outcome != NOBALL);
  assign is_wicket = (outcome == WICKET);

endmodule

// File: rtl/t20_innings_scorer.sv
// rtl/t20_innings_scorer.sv - scores one T20 innings from LFSR-driven deliveries
module t20_innings_scorer
  import t20_pkg::*;
#(
  parameter int MAX_OVERS   = 20,
  parameter int MAX_WICKETS = 10,
  parameter int RUN_W       = 10,
  parameter int RUN_SAT     = 999
) (
  input  logic             clk_fpga,
  input  logic             reset_n,
  input  logic             start,
  input  logic             chase_en,
  input  logic [RUN_W-1:0] target,
  input  logic             delivery,
  input  logic [3:0]       lfsr_val,
  output logic [RUN_W-1:0] runs,
  output logic [3:0]       wickets,
  output logic [4:0]       overs,
  output logic [2:0]       balls,
  output logic             free_hit,
  output logic [3:0]       outcome_code,
  output logic             outcome_valid,
  output logic             innings_done
);

  localparam logic [RUN_W:0]   SAT_EXT = (RUN_W+1)'(RUN_SAT);
  localparam logic [RUN_W-1:0] SAT_VAL = RUN_W'(RUN_SAT);

  state_e           state_q, state_d;
  logic             delivery_q, del_edge;
  logic             chase_q;
  logic [RUN_W-1:0] target_q;
  outcome_e         code_q;

  outcome_e         dec_outcome, eff_outcome;
  logic [2:0]       dec_delta, eff_delta;
  logic             dec_legal, dec_wicket, eff_wicket;
  logic [RUN_W:0]   runs_sum;
  logic [RUN_W-1:0] runs_nx;
  logic [3:0]       wickets_nx;
  logic [4:0]       overs_nx;
  logic [2:0]       balls_nx;
  logic             free_hit_nx, terminate, count_en, start_en;

  t20_outcome_decode u_decode (
    .lfsr_val  (lfsr_val),
    .outcome   (dec_outcome),
    .run_delta (dec_delta),
    .legal     (dec_legal),
    .is_wicket (dec_wicket)
  );

  assign del_edge = delivery & ~delivery_q;
  assign count_en = (state_q == PLAY) && del_edge;
  assign start_en = ((state_q == IDLE) || (state_q == DONE)) && start;

  // Post-update values; a wicket on a free hit is scored as a legal dot ball.
  always_comb begin
    eff_outcome = dec_outcome;
    eff_delta   = dec_delta;
    eff_wicket  = dec_wicket;
    if (dec_wicket && free_hit) begin
      eff_outcome = DOT;
      eff_delta   = 3'd0;
      eff_wicket  = 1'b0;
    end
    runs_sum   = {1'b0, runs} + {{(RUN_W-2){1'b0}}, eff_delta};
    runs_nx    = (runs_sum > SAT_EXT) ? SAT_VAL : runs_sum[RUN_W-1:0];
    wickets_nx = wickets + {3'b000, eff_wicket};
    balls_nx   = balls;
    overs_nx   = overs;
    if (dec_legal) begin
      if (balls == 3'(BALLS_PER_OVER-1)) begin
        balls_nx = 3'd0;
        overs_nx = overs + 5'd1;
      end else begin
        balls_nx = balls + 3'd1;
      end
    end
    if (eff_outcome == NOBALL) free_hit_nx = 1'b1;
    else if (dec_legal)        free_hit_nx = 1'b0;
    else                       free_hit_nx = free_hit;
    terminate = (wickets_nx == 4'(MAX_WICKETS)) ||
                (overs_nx == 5'(MAX_OVERS)) ||
                (chase_q && (runs_nx >= target_q));
  end

  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = PLAY;
      PLAY:    if (count_en && terminate) state_d = DONE;
      DONE:    if (start) state_d = PLAY;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    innings_done = (state_q == DONE);
    outcome_code = code_q;
  end

  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) begin
      delivery_q    <= 1'b1;
      runs          <= '0;
      wickets       <= '0;
      overs         <= '0;
      balls         <= '0;
      free_hit      <= 1'b0;
      code_q        <= DOT;
      outcome_valid <= 1'b0;
      chase_q       <= 1'b0;
      target_q      <= '0;
    end else begin
      delivery_q    <= delivery;
      outcome_valid <= 1'b0;
      if (start_en) begin
        runs     <= '0;
        wickets  <= '0;
        overs    <= '0;
        balls    <= '0;
        free_hit <= 1'b0;
        code_q   <= DOT;
        chase_q  <= chase_en;
        target_q <= target;
      end else if (count_en) begin
        runs          <= runs_nx;
        wickets       <= wickets_nx;
        overs         <= overs_nx;
        balls         <= balls_nx;
        free_hit      <= free_hit_nx;
        code_q        <= eff_outcome;
        outcome_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_t20_innings_scorer.sv
// tb/tb_t20_innings_scorer.sv - randomized and directed checks against a scoring model
module tb_t20_innings_scorer;
  localparam int RUN_W = 10;

  logic             clk_fpga = 1'b0;
  logic             reset_n  = 1'b0;
  logic             start    = 1'b0;
  logic             chase_en = 1'b0;
  logic [RUN_W-1:0] target   = '0;
  logic             delivery = 1'b0;
  logic [3:0]       lfsr_val = 4'd0;
  logic [RUN_W-1:0] runs;
  logic [3:0]       wickets;
  logic [4:0]       overs;
  logic [2:0]       balls;
  logic             free_hit;
  logic [3:0]       outcome_code;
  logic             outcome_valid;
  logic             innings_done;

  always #5 clk_fpga = ~clk_fpga;

  t20_innings_scorer dut (
    .clk_fpga      (clk_fpga),
    .reset_n       (reset_n),
    .start         (start),
    .chase_en      (chase_en),
    .target        (target),
    .delivery      (delivery),
    .lfsr_val      (lfsr_val),
    .runs          (runs),
    .wickets       (wickets),
    .overs         (overs),
    .balls         (balls),
    .free_hit      (free_hit),
    .outcome_code  (outcome_code),
    .outcome_valid (outcome_valid),
    .innings_done  (innings_done)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: innings kept as totals; overs/balls derived from total legal balls.
  int m_state, m_runs, m_wkts, m_legal, m_fh, m_code, m_valid, m_prev, m_chase, m_target;
  int run_tab  [16] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 3, 4, 6, 1, 1, 0};
  int code_tab [16] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 3, 4, 5, 6, 7, 8};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_runs = 0; m_wkts = 0; m_legal = 0; m_fh = 0;
    m_code = 0; m_valid = 0; m_prev = 1; m_chase = 0; m_target = 0;
  endtask

  task automatic model_step();
    int v, r, lg, wk;
    bit edge_seen;
    edge_seen = delivery && (m_prev == 0);
    m_valid = 0;
    if ((m_state != 1) && start) begin
      m_state = 1; m_runs = 0; m_wkts = 0; m_legal = 0; m_fh = 0; m_code = 0;
      m_chase = chase_en; m_target = target;
    end else if ((m_state == 1) && edge_seen) begin
      v  = lfsr_val;
      r  = run_tab[v];
      lg = (v != 13 && v != 14);
      wk = (v == 15 && m_fh == 0);
      m_code = (v == 15 && m_fh != 0) ? 0 : code_tab[v];
      m_runs = (m_runs + r > 999) ? 999 : m_runs + r;
      m_wkts += wk;
      m_legal += lg;
      m_fh = (v == 14) ? 1 : (lg ? 0 : m_fh);
      m_valid = 1;
      if (m_wkts == 10 || m_legal / 6 == 20 || (m_chase != 0 && m_runs >= m_target))
        m_state = 2;
    end
    m_prev = delivery;
  endtask

  task automatic tick();
    @(posedge clk_fpga);
    if (!reset_n) model_reset();
    else          model_step();
    #1;
  endtask

  always @(negedge clk_fpga) begin
    if (chk_en) begin
      check("runs",          int'(runs),          m_runs);
      check("wickets",       int'(wickets),       m_wkts);
      check("overs",         int'(overs),         m_legal / 6);
      check("balls",         int'(balls),         m_legal % 6);
      check("free_hit",      int'(free_hit),      m_fh);
      check("outcome_code",  int'(outcome_code),  m_code);
      check("outcome_valid", int'(outcome_valid), m_valid);
      check("innings_done",  int'(innings_done),  (m_state == 2) ? 1 : 0);
    end
  end

  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("areset_runs",  int'(runs),          0);
    check("areset_wkts",  int'(wickets),       0);
    check("areset_done",  int'(innings_done),  0);
    check("areset_valid", int'(outcome_valid), 0);
    check("areset_balls", int'(balls),         0);
    tick();
    reset_n = 1'b1;
  endtask

  task automatic new_innings(input bit ce, input int tgt);
    async_reset();
    delivery = 1'b0; chase_en = ce; target = RUN_W'(tgt); start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  int pv;
  task automatic press(input int v);
    lfsr_val = 4'(v); delivery = 1'b1;
    tick();
    pv = outcome_valid;
    delivery = 1'b0;
    tick();
  endtask

  int pulses;

  initial begin
    model_reset();
    chk_en = 1'b1;
    tick(); tick();
    check("rst_code", int'(outcome_code), 0);
    reset_n = 1'b1;
    tick();

    // first ball
    start = 1'b1; tick(); start = 1'b0;
    lfsr_val = 4'd4; delivery = 1'b1; tick();
    check("first_valid", int'(outcome_valid), 1);
    check("first_code",  int'(outcome_code),  1);
    delivery = 1'b0; tick();
    check("first_runs",  int'(runs),  1);
    check("first_balls", int'(balls), 1);
    check("first_valid_drop", int'(outcome_valid), 0);

    // over rollover then a wide
    new_innings(1'b0, 0);
    for (int i = 0; i < 6; i++) press(12);
    check("over_runs",  int'(runs),  36);
    check("over_overs", int'(overs), 1);
    check("over_balls", int'(balls), 0);
    press(13);
    check("wide_runs",  int'(runs),  37);
    check("wide_balls", int'(balls), 0);

    // free hit
    new_innings(1'b0, 0);
    press(14);
    check("nb_fh", int'(free_hit), 1);
    press(15);
    check("fh_runs", int'(runs), 1);
    check("fh_wkts", int'(wickets), 0);
    check("fh_code", int'(outcome_code), 0);
    check("fh_balls", int'(balls), 1);
    check("fh_clear", int'(free_hit), 0);
    press(15);
    check("fh_after_wkt", int'(wickets), 1);

    // all out
    new_innings(1'b0, 0);
    for (int i = 0; i < 10; i++) press(15);
    check("allout_wkts", int'(wickets), 10);
    check("allout_done", int'(innings_done), 1);
    press(12);
    check("allout_novalid", pv, 0);
    check("allout_runs", int'(runs), 0);

    // chase
    new_innings(1'b1, 10);
    press(12);
    check("chase_mid_done", int'(innings_done), 0);
    press(11);
    check("chase_runs", int'(runs), 10);
    check("chase_done", int'(innings_done), 1);
    start = 1'b1; tick(); start = 1'b0; tick();
    check("restart_runs", int'(runs), 0);
    check("restart_done", int'(innings_done), 0);

    // zero target
    new_innings(1'b1, 0);
    press(0);
    check("zero_target_done", int'(innings_done), 1);

    // held delivery
    new_innings(1'b0, 0);
    lfsr_val = 4'd4; delivery = 1'b1; pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      pulses += outcome_valid;
    end
    delivery = 1'b0; tick();
    check("hold_pulses", pulses, 1);
    check("hold_runs", int'(runs), 1);
    async_reset();
    tick();

    // random innings
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 999) == 0) async_reset();
      start    = ($urandom_range(0, 15) == 0);
      chase_en = $urandom_range(0, 1);
      target   = RUN_W'($urandom_range(0, 150));
      delivery = $urandom_range(0, 1);
      lfsr_val = 4'($urandom_range(0, 15));
      tick();
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
